// File: rtl/rc_pkg.sv
// Shared constants, state encoding and debug view for the rate_controller
// front-end sequencer.
package rc_pkg;

   localparam logic [7:0] CONFIG_PHASE = 8'hC0;
   localparam logic [7:0] DATA_PHASE   = 8'h5F;
   localparam logic [7:0] NULL_TAG     = 8'h00;

   localparam int PARAM_SIZE = 32;
   localparam int OFF_D      = 0;
   localparam int OFF_N      = 32;
   localparam int OFF_P      = 64;
   localparam int OFF_Q      = 96;
   localparam int OFF_F      = 128;

   typedef enum logic [2:0] {
      IDLE,
      CFG_SEND,
      CFG_ACK,
      DATA,
      GAP,
      NULL_SEND
   } rc_state_t;

   typedef struct packed {
      rc_state_t state;
      logic      configured;
      logic      pkt_open;
   } rc_dbg_t;

   // A config is unusable when it asks for zero flits or a fill beyond the period.
   function automatic logic cfg_bad(input logic [31:0] n, input logic [31:0] p,
                                    input logic [31:0] f);
      return (n == 32'd0) || (f > p);
   endfunction

endpackage

// File: rtl/rc_down_counter.sv
// 32-bit loadable down counter that stops at zero; used as gap timer and ack timeout.
module rc_down_counter
   import rc_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_load,
   input  logic [PARAM_SIZE-1:0] i_load_val,
   input  logic                  i_dec,
   output logic [PARAM_SIZE-1:0] o_count,
   output logic                  o_zero
);

   logic [PARAM_SIZE-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/rc_sequencer.sv
// Front-end sequencer: sends the config flit, waits for the null-flit ack,
// then forwards tagged payload with a programmable gap and a trailing null flit.
module rc_sequencer
   import rc_pkg::*;
#(
   parameter int DATA_W      = 256,
   parameter int USER_W      = DATA_W / 2,
   parameter int TAG_W       = DATA_W / 8,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [31:0]       cfg_d,
   input  logic [31:0]       cfg_n,
   input  logic [31:0]       cfg_p,
   input  logic [31:0]       cfg_q,
   input  logic [31:0]       cfg_f,
   input  logic              src_tvalid,
   input  logic [DATA_W-1:0] src_tdata,
   input  logic [USER_W-1:0] src_tuser,
   input  logic [TAG_W-1:0]  src_tstrb,
   input  logic              src_tlast,
   output logic              src_tready,
   output logic              rc_in_tvalid,
   output logic [DATA_W-1:0] rc_in_tdata,
   output logic [USER_W-1:0] rc_in_tuser,
   output logic [TAG_W-1:0]  rc_in_tstrb,
   output logic              rc_in_tlast,
   output logic [TAG_W-1:0]  rc_in_tag,
   input  logic              rc_in_tready,
   input  logic              mon_tvalid,
   input  logic              mon_tready,
   input  logic              mon_tlast,
   input  logic [TAG_W-1:0]  mon_tag,
   output logic              busy,
   output logic              cfg_err,
   output logic [31:0]       pkt_count,
   output rc_dbg_t           dbg
);

   localparam logic [TAG_W-1:0] W_TAG_CFG  = TAG_W'(CONFIG_PHASE);
   localparam logic [TAG_W-1:0] W_TAG_DATA = TAG_W'(DATA_PHASE);
   localparam logic [TAG_W-1:0] W_TAG_NULL = TAG_W'(NULL_TAG);

   rc_state_t   r_state;
   logic [31:0] r_d, r_n, r_p, r_q, r_f;
   logic        r_configured;
   logic        r_pkt_open;
   logic        r_cfg_err;
   logic [31:0] r_pkt_count;

   logic              w_cfg_bad;
   logic              w_cfg_take;
   logic              w_cfg_accept;
   logic              w_src_hs;
   logic              w_null_hs;
   logic              w_ack;
   logic              w_gap_load;
   logic              w_ack_load;
   logic [31:0]       w_gap_cnt;
   logic              w_gap_zero;
   logic [31:0]       w_ack_cnt;
   logic              w_ack_zero;
   logic              w_gap_exit;
   logic              w_ack_exit;
   logic [DATA_W-1:0] w_cfg_data;

   // Config outranks payload in DATA only while no packet is in flight.
   assign w_cfg_bad    = cfg_bad(cfg_n, cfg_p, cfg_f);
   assign w_cfg_take   = (r_state == DATA) && cfg_valid && !r_pkt_open;
   assign w_cfg_accept = cfg_valid && !w_cfg_bad && ((r_state == IDLE) || w_cfg_take);
   assign w_src_hs     = (r_state == DATA) && !w_cfg_take && src_tvalid && rc_in_tready;
   assign w_null_hs    = (r_state == NULL_SEND) && rc_in_tready;
   assign w_ack        = mon_tvalid && mon_tready && mon_tlast && (mon_tag == W_TAG_NULL);

   assign w_gap_load = (r_d != 32'd0) && ((w_src_hs && !src_tlast) || w_null_hs);
   assign w_ack_load = (r_state == CFG_SEND) && rc_in_tready;
   assign w_gap_exit = (w_gap_cnt == 32'd1) || w_gap_zero;
   assign w_ack_exit = (w_ack_cnt == 32'd1) || w_ack_zero;

   rc_down_counter u_gap_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_gap_load),
      .i_load_val (r_d),
      .i_dec      (r_state == GAP),
      .o_count    (w_gap_cnt),
      .o_zero     (w_gap_zero)
   );

   rc_down_counter u_ack_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_ack_load),
      .i_load_val (32'(ACK_TIMEOUT)),
      .i_dec      ((r_state == CFG_ACK) && !w_ack),
      .o_count    (w_ack_cnt),
      .o_zero     (w_ack_zero)
   );

   always_comb begin
      w_cfg_data = '0;
      w_cfg_data[OFF_D +: PARAM_SIZE] = r_d;
      w_cfg_data[OFF_N +: PARAM_SIZE] = r_n;
      w_cfg_data[OFF_P +: PARAM_SIZE] = r_p;
      w_cfg_data[OFF_Q +: PARAM_SIZE] = r_q;
      w_cfg_data[OFF_F +: PARAM_SIZE] = r_f;
   end

   always_comb begin
      cfg_ready    = 1'b0;
      src_tready   = 1'b0;
      rc_in_tvalid = 1'b0;
      rc_in_tdata  = '0;
      rc_in_tuser  = '0;
      rc_in_tstrb  = '0;
      rc_in_tlast  = 1'b0;
      rc_in_tag    = W_TAG_NULL;
      case (r_state)
         IDLE: begin
            // Gated by reset so every output reads 0 while reset is held.
            cfg_ready = reset;
         end
         CFG_SEND: begin
            rc_in_tvalid = 1'b1;
            rc_in_tdata  = w_cfg_data;
            rc_in_tstrb  = '1;
            rc_in_tlast  = 1'b1;
            rc_in_tag    = W_TAG_CFG;
         end
         DATA: begin
            cfg_ready    = !r_pkt_open;
            src_tready   = rc_in_tready && !w_cfg_take;
            rc_in_tvalid = src_tvalid && !w_cfg_take;
            rc_in_tdata  = src_tdata;
            rc_in_tuser  = src_tuser;
            rc_in_tstrb  = src_tstrb;
            rc_in_tlast  = src_tlast;
            rc_in_tag    = W_TAG_DATA;
         end
         NULL_SEND: begin
            rc_in_tvalid = 1'b1;
            rc_in_tlast  = 1'b1;
         end
         default: begin
            cfg_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_d <= '0;
         r_n <= '0;
         r_p <= '0;
         r_q <= '0;
         r_f <= '0;
      end else if (w_cfg_accept) begin
         r_d <= cfg_d;
         r_n <= cfg_n;
         r_p <= cfg_p;
         r_q <= cfg_q;
         r_f <= cfg_f;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_configured <= 1'b0;
         r_pkt_open   <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_pkt_count  <= '0;
      end else begin
         r_cfg_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cfg_valid) begin
                  if (w_cfg_bad) r_cfg_err <= 1'b1;
                  else           r_state   <= CFG_SEND;
               end
            end
            CFG_SEND: begin
               if (rc_in_tready) r_state <= CFG_ACK;
            end
            CFG_ACK: begin
               if (w_ack) begin
                  r_configured <= 1'b1;
                  r_state      <= DATA;
               end else if (w_ack_exit) begin
                  r_cfg_err    <= 1'b1;
                  r_configured <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            DATA: begin
               if (w_cfg_take) begin
                  if (w_cfg_bad) r_cfg_err <= 1'b1;
                  else           r_state   <= CFG_SEND;
               end else if (w_src_hs) begin
                  r_pkt_open <= !src_tlast;
                  if (src_tlast)           r_state <= NULL_SEND;
                  else if (r_d != 32'd0)   r_state <= GAP;
               end
            end
            GAP: begin
               if (w_gap_exit) r_state <= DATA;
            end
            NULL_SEND: begin
               if (rc_in_tready) begin
                  r_pkt_count <= r_pkt_count + 32'd1;
                  r_state     <= (r_d != 32'd0) ? GAP : DATA;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy           = (r_state != IDLE);
   assign cfg_err        = r_cfg_err;
   assign pkt_count      = r_pkt_count;
   assign dbg.state      = r_state;
   assign dbg.configured = r_configured;
   assign dbg.pkt_open   = r_pkt_open;

endmodule

// File: tb/tb_rc_sequencer.sv
// Directed bench for rc_sequencer: config/ack, gapped and back-pressured
// packets, mid-packet reconfig, ack timeout, rejected configs and async reset.
module tb_rc_sequencer;
   import rc_pkg::*;

   localparam int DATA_W = 256;
   localparam int USER_W = 128;
   localparam int TAG_W  = 32;
   localparam int ACK_TO = 16;

   localparam logic [TAG_W-1:0] T_CFG  = 32'h0000_00C0;
   localparam logic [TAG_W-1:0] T_DATA = 32'h0000_005F;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [31:0]       cfg_d = '0, cfg_n = '0, cfg_p = '0, cfg_q = '0, cfg_f = '0;
   logic              src_tvalid = 1'b0;
   logic [DATA_W-1:0] src_tdata = '0;
   logic [USER_W-1:0] src_tuser = '0;
   logic [TAG_W-1:0]  src_tstrb = '0;
   logic              src_tlast = 1'b0;
   logic              src_tready;
   logic              rc_in_tvalid;
   logic [DATA_W-1:0] rc_in_tdata;
   logic [USER_W-1:0] rc_in_tuser;
   logic [TAG_W-1:0]  rc_in_tstrb;
   logic              rc_in_tlast;
   logic [TAG_W-1:0]  rc_in_tag;
   logic              rc_in_tready = 1'b1;
   logic              mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
   logic [TAG_W-1:0]  mon_tag = '0;
   logic              busy;
   logic              cfg_err;
   logic [31:0]       pkt_count;
   rc_dbg_t           dbg;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   rc_sequencer #(
      .DATA_W(DATA_W), .USER_W(USER_W), .TAG_W(TAG_W), .ACK_TIMEOUT(ACK_TO)
   ) dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_d(cfg_d), .cfg_n(cfg_n), .cfg_p(cfg_p), .cfg_q(cfg_q), .cfg_f(cfg_f),
      .src_tvalid(src_tvalid), .src_tdata(src_tdata), .src_tuser(src_tuser),
      .src_tstrb(src_tstrb), .src_tlast(src_tlast), .src_tready(src_tready),
      .rc_in_tvalid(rc_in_tvalid), .rc_in_tdata(rc_in_tdata), .rc_in_tuser(rc_in_tuser),
      .rc_in_tstrb(rc_in_tstrb), .rc_in_tlast(rc_in_tlast), .rc_in_tag(rc_in_tag),
      .rc_in_tready(rc_in_tready),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
      .mon_tag(mon_tag),
      .busy(busy), .cfg_err(cfg_err), .pkt_count(pkt_count), .dbg(dbg)
   );

   function automatic logic [DATA_W-1:0] pay_data(input int k);
      return {8{32'hD00D_0000 + 32'(k)}};
   endfunction

   function automatic logic [USER_W-1:0] pay_user(input int k);
      return {4{32'hC0DE_0000 + 32'(k)}};
   endfunction

   function automatic logic [TAG_W-1:0] pay_strb(input int k);
      return 32'h0F0F_0000 | 32'(k);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_src(input int k, input int n, input int base);
      if (k < n) begin
         src_tvalid = 1'b1;
         src_tdata  = pay_data(base + k);
         src_tuser  = pay_user(base + k);
         src_tstrb  = pay_strb(base + k);
         src_tlast  = (k == n - 1);
      end else begin
         src_tvalid = 1'b0;
         src_tdata  = '0;
         src_tuser  = '0;
         src_tstrb  = '0;
         src_tlast  = 1'b0;
      end
   endtask

   task automatic set_cfg(input logic [31:0] d, input logic [31:0] n, input logic [31:0] p,
                          input logic [31:0] q, input logic [31:0] f);
      cfg_d = d; cfg_n = n; cfg_p = p; cfg_q = q; cfg_f = f;
   endtask

   task automatic mon_null(input logic on);
      mon_tvalid = on; mon_tready = on; mon_tlast = on; mon_tag = '0;
   endtask

   // Accept a config, let the config flit go, and return the null-flit ack.
   task automatic cfg_and_ack(input logic [31:0] d, input logic [31:0] n, input logic [31:0] p,
                              input logic [31:0] q, input logic [31:0] f);
      int w;
      rc_in_tready = 1'b1;
      set_cfg(d, n, p, q, f);
      cfg_valid = 1'b1;
      #1;
      w = 0;
      while (!cfg_ready && w < 20) begin
         tick;
         w++;
      end
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_and_ack_ready: cfg_ready=%b after %0d cycles, need 1", cfg_ready, w);
      end
      tick;
      cfg_valid = 1'b0;
      #1;
      n_tests++;
      if (rc_in_tvalid !== 1'b1 || rc_in_tag !== T_CFG || rc_in_tdata[31:0] !== d) begin
         n_fail++;
         $display("FAIL cfg_and_ack_flit: valid=%b tag=%h d=%0d, need 1 %h %0d",
                  rc_in_tvalid, rc_in_tag, rc_in_tdata[31:0], T_CFG, d);
      end
      tick;
      tick;
      mon_null(1'b1);
      tick;
      mon_null(1'b0);
      n_tests++;
      if (dbg.state !== DATA) begin
         n_fail++;
         $display("FAIL cfg_and_ack_state: state=%0d, need %0d", dbg.state, DATA);
      end
   endtask

   task automatic test_reset;
      #2;
      n_tests++;
      if ({cfg_ready, src_tready, rc_in_tvalid, busy, cfg_err} !== 5'b0 || pkt_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_held: rdy=%b srdy=%b vld=%b busy=%b err=%b cnt=%0d, need all 0",
                  cfg_ready, src_tready, rc_in_tvalid, busy, cfg_err, pkt_count);
      end
      tick;
      tick;
      reset = 1'b1;
      #1;
      n_tests++;
      if (cfg_ready !== 1'b1 || src_tready !== 1'b0 || dbg.state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_idle: cfg_ready=%b src_tready=%b state=%0d, need 1 0 %0d",
                  cfg_ready, src_tready, dbg.state, IDLE);
      end
      tick;
      n_tests++;
      if (busy !== 1'b0 || rc_in_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: busy=%b rc_in_tvalid=%b, need 0 0", busy, rc_in_tvalid);
      end
   endtask

   task automatic test_config;
      rc_in_tready = 1'b1;
      set_cfg(32'd2, 32'd1, 32'd64, 32'd32, 32'd64);
      cfg_valid = 1'b1;
      #1;
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL config_ready: cfg_ready=%b, need 1", cfg_ready);
      end
      tick;
      cfg_valid = 1'b0;
      #1;
      n_tests++;
      if (rc_in_tvalid !== 1'b1 || rc_in_tag !== T_CFG || rc_in_tlast !== 1'b1) begin
         n_fail++;
         $display("FAIL config_flit_hdr: valid=%b tag=%h last=%b, need 1 %h 1",
                  rc_in_tvalid, rc_in_tag, rc_in_tlast, T_CFG);
      end
      n_tests++;
      if (rc_in_tdata[159:0] !== {32'd64, 32'd32, 32'd64, 32'd1, 32'd2} ||
          rc_in_tdata[255:160] !== 96'd0) begin
         n_fail++;
         $display("FAIL config_flit_data: tdata=%h", rc_in_tdata);
      end
      n_tests++;
      if (rc_in_tstrb !== 32'hFFFF_FFFF || rc_in_tuser !== 128'd0) begin
         n_fail++;
         $display("FAIL config_flit_side: tstrb=%h tuser=%h, need ffffffff 0", rc_in_tstrb, rc_in_tuser);
      end
      tick;
      n_tests++;
      if (rc_in_tvalid !== 1'b0 || dbg.state !== CFG_ACK) begin
         n_fail++;
         $display("FAIL config_wait_ack: valid=%b state=%0d, need 0 %0d", rc_in_tvalid, dbg.state, CFG_ACK);
      end
      tick;
      tick;
      mon_null(1'b1);
      tick;
      mon_null(1'b0);
      #1;
      n_tests++;
      if (dbg.state !== DATA || busy !== 1'b1 || dbg.configured !== 1'b1 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL config_acked: state=%0d busy=%b configured=%b err=%b, need %0d 1 1 0",
                  dbg.state, busy, dbg.configured, cfg_err, DATA);
      end
   endtask

   task automatic test_gap_packet;
      int k;
      int hs_c[3];
      int null_c;
      logic [11:0] vld;
      k = 0;
      null_c = -1;
      vld = '0;
      for (int i = 0; i < 3; i++) hs_c[i] = -1;
      rc_in_tready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         drive_src(k, 3, 0);
         #1;
         vld[c] = rc_in_tvalid;
         if (c == 1) begin
            n_tests++;
            if (src_tready !== 1'b0 || dbg.state !== GAP) begin
               n_fail++;
               $display("FAIL gap_stall: src_tready=%b state=%0d, need 0 %0d", src_tready, dbg.state, GAP);
            end
         end
         if (rc_in_tvalid && rc_in_tready) begin
            if (rc_in_tag === T_DATA) begin
               if (k < 3) begin
                  hs_c[k] = c;
                  n_tests++;
                  if (rc_in_tdata !== pay_data(k) || rc_in_tuser !== pay_user(k) ||
                      rc_in_tstrb !== pay_strb(k) || rc_in_tlast !== (k == 2)) begin
                     n_fail++;
                     $display("FAIL gap_payload%0d: data=%h last=%b", k, rc_in_tdata, rc_in_tlast);
                  end
               end
               k++;
            end else if (rc_in_tag === '0 && rc_in_tlast === 1'b1) begin
               null_c = c;
               n_tests++;
               if (rc_in_tdata !== '0 || rc_in_tuser !== '0 || rc_in_tstrb !== '0) begin
                  n_fail++;
                  $display("FAIL gap_null_body: data=%h user=%h strb=%h, need 0", rc_in_tdata,
                           rc_in_tuser, rc_in_tstrb);
               end
            end
         end
         tick;
      end
      n_tests++;
      if (k != 3 || hs_c[0] != 0 || hs_c[1] != 3 || hs_c[2] != 6) begin
         n_fail++;
         $display("FAIL gap_timing: flits=%0d at %0d,%0d,%0d, need 3 at 0,3,6", k, hs_c[0], hs_c[1], hs_c[2]);
      end
      n_tests++;
      if (null_c != 7 || vld !== 12'h0C9) begin
         n_fail++;
         $display("FAIL gap_null: null at %0d valid map %h, need 7 and 0c9", null_c, vld);
      end
      n_tests++;
      if (pkt_count !== 32'd1) begin
         n_fail++;
         $display("FAIL gap_pkt_count: pkt_count=%0d, need 1", pkt_count);
      end
   endtask

   task automatic test_back_to_back;
      int k;
      int n_rx;
      int null_c;
      int hs_c[4];
      logic [DATA_W-1:0] exp;
      cfg_and_ack(32'd0, 32'd1, 32'd64, 32'd32, 32'd64);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(pay_data(i));
         hs_c[i] = -1;
      end
      k = 0;
      n_rx = 0;
      null_c = -1;
      for (int c = 0; c < 12; c++) begin
         rc_in_tready = ((c % 2) == 0);
         drive_src(k, 4, 0);
         #1;
         if (c == 1) begin
            n_tests++;
            if (src_tready !== 1'b0 || rc_in_tvalid !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_backpressure: src_tready=%b valid=%b, need 0 1", src_tready, rc_in_tvalid);
            end
         end
         if (rc_in_tvalid && rc_in_tready) begin
            if (rc_in_tag === T_DATA) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL b2b_extra: unexpected flit %h at cycle %0d", rc_in_tdata, c);
               end else begin
                  exp = exp_q.pop_front();
                  if (rc_in_tdata !== exp || rc_in_tlast !== (n_rx == 3)) begin
                     n_fail++;
                     $display("FAIL b2b_payload%0d: data=%h last=%b, need %h %b", n_rx, rc_in_tdata,
                              rc_in_tlast, exp, (n_rx == 3));
                  end
               end
               if (n_rx < 4) hs_c[n_rx] = c;
               n_rx++;
               k++;
            end else if (rc_in_tag === '0 && rc_in_tlast === 1'b1) begin
               null_c = c;
            end else begin
               n_tests++;
               n_fail++;
               $display("FAIL b2b_tag: tag=%h at cycle %0d, need %h", rc_in_tag, c, T_DATA);
            end
         end
         tick;
      end
      rc_in_tready = 1'b1;
      n_tests++;
      if (n_rx != 4 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_count: received %0d left %0d, need 4 and 0", n_rx, exp_q.size());
      end
      n_tests++;
      if (hs_c[0] != 0 || hs_c[1] != 2 || hs_c[2] != 4 || hs_c[3] != 6 || null_c != 8) begin
         n_fail++;
         $display("FAIL b2b_timing: flits %0d,%0d,%0d,%0d null %0d, need 0,2,4,6 null 8",
                  hs_c[0], hs_c[1], hs_c[2], hs_c[3], null_c);
      end
      n_tests++;
      if (pkt_count !== 32'd2) begin
         n_fail++;
         $display("FAIL b2b_pkt_count: pkt_count=%0d, need 2", pkt_count);
      end
   endtask

   task automatic test_midpacket_cfg;
      int k;
      int acc_c;
      logic [8:0] rdy;
      int cyc_q[$];
      logic [TAG_W-1:0] tag_q[$];
      cfg_and_ack(32'd1, 32'd2, 32'd8, 32'd4, 32'd8);
      k = 0;
      acc_c = -1;
      rdy = '0;
      for (int c = 0; c < 9; c++) begin
         if (k < 2) drive_src(k, 2, 20);
         else       drive_src(0, 3, 30);
         if (c == 1) begin
            set_cfg(32'd3, 32'd2, 32'd16, 32'd8, 32'd16);
            cfg_valid = 1'b1;
         end
         mon_null(c == 7);
         #1;
         rdy[c] = cfg_ready;
         if (cfg_valid && cfg_ready) acc_c = c;
         if (c == 5) begin
            n_tests++;
            if (src_tready !== 1'b0 || rc_in_tvalid !== 1'b0) begin
               n_fail++;
               $display("FAIL mid_cfg_priority: src_tready=%b valid=%b, need 0 0", src_tready, rc_in_tvalid);
            end
         end
         if (rc_in_tvalid && rc_in_tready) begin
            cyc_q.push_back(c);
            tag_q.push_back(rc_in_tag);
            if (rc_in_tag === T_CFG) begin
               n_tests++;
               if (rc_in_tdata[31:0] !== 32'd3 || rc_in_tdata[63:32] !== 32'd2) begin
                  n_fail++;
                  $display("FAIL mid_cfg_flit: D=%0d N=%0d, need 3 2", rc_in_tdata[31:0], rc_in_tdata[63:32]);
               end
            end else if (rc_in_tag === T_DATA) begin
               k++;
            end
         end
         tick;
         if (acc_c >= 0) cfg_valid = 1'b0;
      end
      mon_null(1'b0);
      n_tests++;
      if (acc_c != 5 || rdy[5:1] !== 5'b10000) begin
         n_fail++;
         $display("FAIL mid_cfg_ready: accepted at %0d ready map c1..c5=%b, need 5 and 10000", acc_c, rdy[5:1]);
      end
      n_tests++;
      if (cyc_q.size() != 5) begin
         n_fail++;
         $display("FAIL mid_cfg_flits: %0d handshakes, need 5", cyc_q.size());
      end else if (cyc_q[0] != 0 || cyc_q[1] != 2 || cyc_q[2] != 3 || cyc_q[3] != 6 || cyc_q[4] != 8 ||
                   tag_q[0] !== T_DATA || tag_q[1] !== T_DATA || tag_q[2] !== '0 ||
                   tag_q[3] !== T_CFG || tag_q[4] !== T_DATA) begin
         n_fail++;
         $display("FAIL mid_cfg_order: cycles %0d %0d %0d %0d %0d tags %h %h %h %h %h",
                  cyc_q[0], cyc_q[1], cyc_q[2], cyc_q[3], cyc_q[4],
                  tag_q[0], tag_q[1], tag_q[2], tag_q[3], tag_q[4]);
      end
      n_tests++;
      if (pkt_count !== 32'd3) begin
         n_fail++;
         $display("FAIL mid_cfg_pkt_count: pkt_count=%0d, need 3", pkt_count);
      end
   endtask

   task automatic test_reset_in_gap;
      n_tests++;
      if (dbg.state !== GAP) begin
         n_fail++;
         $display("FAIL rst_gap_pre: state=%0d, need %0d", dbg.state, GAP);
      end
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if ({cfg_ready, src_tready, rc_in_tvalid, busy, cfg_err, dbg.configured} !== 6'b0 ||
          pkt_count !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_gap_async: rdy=%b srdy=%b vld=%b busy=%b err=%b cfgd=%b cnt=%0d, need all 0",
                  cfg_ready, src_tready, rc_in_tvalid, busy, cfg_err, dbg.configured, pkt_count);
      end
      drive_src(1, 0, 0);
      tick;
      reset = 1'b1;
      #1;
      n_tests++;
      if (cfg_ready !== 1'b1 || dbg.state !== IDLE) begin
         n_fail++;
         $display("FAIL rst_gap_release: cfg_ready=%b state=%0d, need 1 %0d", cfg_ready, dbg.state, IDLE);
      end
   endtask

   task automatic test_timeout;
      rc_in_tready = 1'b1;
      set_cfg(32'd5, 32'd1, 32'd10, 32'd10, 32'd10);
      cfg_valid = 1'b1;
      tick;
      cfg_valid = 1'b0;
      tick;
      n_tests++;
      if (dbg.state !== CFG_ACK) begin
         n_fail++;
         $display("FAIL timeout_start: state=%0d, need %0d", dbg.state, CFG_ACK);
      end
      for (int k = 1; k <= 17; k++) begin
         mon_tvalid = (k == 5);
         mon_tready = (k == 5);
         mon_tlast  = (k == 5);
         mon_tag    = T_DATA;
         tick;
         mon_null(1'b0);
         n_tests++;
         if (cfg_err !== (k == 16)) begin
            n_fail++;
            $display("FAIL timeout_err_k%0d: cfg_err=%b, need %b", k, cfg_err, (k == 16));
         end
         n_tests++;
         if (k >= 16) begin
            if (dbg.state !== IDLE || rc_in_tvalid !== 1'b0 || dbg.configured !== 1'b0) begin
               n_fail++;
               $display("FAIL timeout_state_k%0d: state=%0d valid=%b cfgd=%b, need %0d 0 0",
                        k, dbg.state, rc_in_tvalid, dbg.configured, IDLE);
            end
         end else if (dbg.state !== CFG_ACK) begin
            n_fail++;
            $display("FAIL timeout_state_k%0d: state=%0d, need %0d", k, dbg.state, CFG_ACK);
         end
      end
   endtask

   task automatic test_reject;
      set_cfg(32'd0, 32'd1, 32'd64, 32'd0, 32'd100);
      cfg_valid = 1'b1;
      #1;
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reject_ready: cfg_ready=%b, need 1", cfg_ready);
      end
      tick;
      cfg_valid = 1'b0;
      n_tests++;
      if (cfg_err !== 1'b1 || dbg.state !== IDLE || rc_in_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reject_fgtp: err=%b state=%0d valid=%b, need 1 %0d 0", cfg_err, dbg.state,
                  rc_in_tvalid, IDLE);
      end
      tick;
      n_tests++;
      if (cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reject_pulse_len: cfg_err=%b, need 0", cfg_err);
      end
      set_cfg(32'd0, 32'd0, 32'd64, 32'd0, 32'd8);
      cfg_valid = 1'b1;
      tick;
      cfg_valid = 1'b0;
      n_tests++;
      if (cfg_err !== 1'b1 || dbg.state !== IDLE) begin
         n_fail++;
         $display("FAIL reject_n0: err=%b state=%0d, need 1 %0d", cfg_err, dbg.state, IDLE);
      end
      set_cfg(32'd0, 32'd1, 32'd64, 32'd0, 32'd64);
      cfg_valid = 1'b1;
      tick;
      cfg_valid = 1'b0;
      n_tests++;
      if (cfg_err !== 1'b0 || dbg.state !== CFG_SEND) begin
         n_fail++;
         $display("FAIL accept_f_eq_p: err=%b state=%0d, need 0 %0d", cfg_err, dbg.state, CFG_SEND);
      end
   endtask

   initial begin
      test_reset;
      test_config;
      test_gap_packet;
      test_back_to_back;
      test_midpacket_cfg;
      test_reset_in_gap;
      test_timeout;
      test_reject;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, need completion");
      $fatal(1, "watchdog");
   end

endmodule
